// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
// Optional early divide-by-zero completion: define MULDIV_EARLY_OUT_EN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wrdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_next;

    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] p;

    logic               is_signed, neg_a, neg_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               accept, early;
    logic               calc_en, fix_en;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_mag, r_mag, q_fix, r_fix;

    // Operand conditioning at capture: signed ops work on magnitudes
    always_comb begin
        is_signed = ~op[0];
        neg_a     = is_signed & rs_data[WIDTH-1];
        neg_b     = is_signed & rt_data[WIDTH-1];
        a_mag     = neg_a ? -rs_data : rs_data;
        b_mag     = neg_b ? -rt_data : rt_data;
        accept    = start && (state == IDLE);
`ifdef MULDIV_EARLY_OUT_EN
        early     = op[1] && (rt_data == '0);
`else
        early     = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = early ? FIX : CALC;
            CALC:    if (count == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        calc_en = (state == CALC);
        fix_en  = (state == FIX);
    end

    // One shift-add or restoring-subtract step per CALC cycle
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, p[WIDTH-1:1]};
        div_shift = {1'b0, p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_diff  = div_shift - {2'b00, opnd};
        div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0],  p[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_q ? -p : p;
        q_mag    = p[WIDTH-1:0];
        r_mag    = p[2*WIDTH-1:WIDTH];
        q_fix    = neg_q ? -q_mag : q_mag;
        r_fix    = neg_r ? -r_mag : r_mag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            p      <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= fix_en;
            if (accept) begin
                is_div <= op[1];
                neg_q  <= neg_a ^ neg_b;
                neg_r  <= neg_a;
                count  <= CW'(WIDTH - 1);
                opnd   <= op[1] ? b_mag : a_mag;
                // Skipping CALC on x/0 preloads what WIDTH restoring steps would leave
                if (early) begin
                    p <= {a_mag, {WIDTH{1'b1}}};
                end else begin
                    p <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                end
            end else if (calc_en) begin
                count <= count - 1'b1;
                p     <= is_div ? div_next : mul_next;
            end

            if (fix_en) begin
                if (is_div) begin
                    hi <= r_fix;
                    lo <= q_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end else if ((state == IDLE) && !start) begin
                if (hi_we) hi <= wrdata;
                if (lo_we) lo <= wrdata;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wrdata = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wrdata(wrdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one instruction, from plain integer arithmetic
    function automatic void model_op(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0;
        l = '0;
        case (o)
            2'b00: begin prod = 64'(sa * sb); h = prod[63:32]; l = prod[31:0]; end
            2'b01: begin prod = {32'h0, a} * {32'h0, b}; h = prod[63:32]; l = prod[31:0]; end
            2'b10: begin
                if (b == 0) begin
                    h = a;
                    l = (sa < 0) ? 32'h1 : 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end
            end
            default: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin h = a % b; l = a / b; end
            end
        endcase
    endfunction

    // Cycle-level expectation: results appear a fixed number of edges after acceptance
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit m_busy = 1'b0, m_done = 1'b0;
    int m_left = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
                end
            end else if (start) begin
                model_op(op, rs_data, rt_data, p_hi, p_lo);
                m_busy = 1'b1;
                m_left = (EARLY && op[1] && rt_data == 0) ? 1 : W + 1;
            end else begin
                if (hi_we) m_hi = wrdata;
                if (lo_we) m_lo = wrdata;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (done) begin cycles = i; break; end
        end
        if (cycles == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    int n;
    int pulses;

    initial begin
        @(negedge clock);
        cmp_en = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        hi_we = 1'b1; lo_we = 1'b1; wrdata = 32'h1111_2222;
        @(negedge clock);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both_hi", hi, 32'h1111_2222);
        check("mt_both_lo", lo, 32'h1111_2222);

        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFE, 32'h3, n);
        check("mult_lat", n, 34 - 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(2'b01, 32'hFFFF_FFFE, 32'h3, n);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, n);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'h0);

        run_op(2'b10, 32'hFFFF_FFF9, 32'h2, n);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, n);
        check("divu_lo", lo, 32'h0FFF_FFFF);
        check("divu_hi", hi, 32'hF);

        run_op(2'b11, 32'h1234_5678, 32'h0, n);
        check("divu0_lat", n, EARLY ? 2 : 34);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'h1234_5678);
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0, n);
        check("div0_neg_lo", lo, 32'h1);
        check("div0_neg_hi", hi, 32'hFFFF_FFF0);
        run_op(2'b10, 32'h0000_0055, 32'h0, n);
        check("div0_pos_lo", lo, 32'hFFFF_FFFF);
        check("div0_pos_hi", hi, 32'h55);
        run_op(2'b01, 32'h3, 32'h4, n);
        check("multu_b2b_lat", n, 34);

        // Start and MTHI during an operation must both be ignored
        @(negedge clock);
        op = 2'b01; rs_data = 32'd5; rt_data = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        op = 2'b11; rs_data = 32'd9; rt_data = 32'd2; start = 1'b1;
        hi_we = 1'b1; wrdata = 32'hDEAD;
        @(negedge clock);
        start = 1'b0; hi_we = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60 && pulses == 0; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("busy_ign_done", pulses, 1);
        check("busy_ign_hi", hi, 32'h0);
        check("busy_ign_lo", lo, 32'd35);

        hi_we = 1'b1; wrdata = 32'hDEAD;
        @(negedge clock);
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'hDEAD);
        check("mthi_lo", lo, 32'd35);
        lo_we = 1'b1; wrdata = 32'h55;
        @(negedge clock);
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h55);

        hi_we = 1'b1; wrdata = 32'hBEEF;
        run_op(2'b01, 32'd2, 32'd3, n);
        check("start_wins_hi", hi, 32'h0);
        check("start_wins_lo", lo, 32'd6);

        // Reset in the middle of a divide aborts it without a done pulse
        @(negedge clock);
        op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (13) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("midrst_nodone", pulses, 0);
        run_op(2'b11, 32'd100, 32'd7, n);
        check("after_rst_lo", lo, 32'd14);
        check("after_rst_hi", hi, 32'd2);

        @(negedge clock);
        @(negedge clock);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath; sits directly downstream of the 32x32 register file.
- Consumes the two register read ports (rs/rt data) and executes MULT, MULTU, DIV and DIVU.
- Holds results in architectural HI/LO registers, which are readable by MFHI/MFLO and writable by MTHI/MTLO.
- Multicycle; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  launch operation; accepted only when busy=0
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start
- rs_data  in  WIDTH  operand A (dividend/multiplicand), from rddata1
- rt_data  in  WIDTH  operand B (divisor/multiplier), from rddata2
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wrdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE. Reset asserted mid-operation aborts it; no HI/LO update and no done pulse.
- FSM states: IDLE, CALC, FIX.
  - IDLE: start=1 at an edge captures op, rs_data and rt_data, sets count=WIDTH-1 and goes to CALC.
  - CALC: performs one iteration per cycle for WIDTH cycles, then goes to FIX.
  - FIX: applies sign correction, writes hi/lo, pulses done, returns to IDLE.
- Latency: capture at edge 0; CALC at edges 1..32; FIX at edge 33.
  - busy=1 from after edge 0 until edge 33.
  - done=1 for exactly the cycle after edge 33; new hi/lo values are visible in that same cycle.
- Signed ops (MULT, DIV): operate on magnitudes of both operands, then sign-fix in FIX. Unsigned ops use operands as-is.
- Multiply: shift-add over a 2*WIDTH product. {hi,lo} = full 64-bit product; no truncation or overflow.
- Divide: restoring division. lo = quotient, hi = remainder.
  - Quotient is negated if operand signs differ.
  - Remainder takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Divide by zero (defined, no trap):
  - DIVU: lo=0xFFFFFFFF, hi=rs.
  - DIV with rs>=0: lo=0xFFFFFFFF, hi=rs.
  - DIV with rs<0: lo=0x00000001, hi=rs.
- start while busy=1: ignored. Not queued; operands are not resampled.
- hi_we/lo_we while idle: hi/lo updated at that edge; both may be written in the same cycle.
- hi_we/lo_we while busy: ignored.
- start and hi_we/lo_we both asserted while idle: start wins; the writes are dropped.
- hi/lo hold their previous values throughout CALC. They change only in FIX, on MTHI/MTLO, or on reset.
- Back-to-back: start may be asserted in the done cycle (busy=0) and is accepted at that edge.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: DIV/DIVU with rt_data=0 goes IDLE -> FIX directly.
  - FIX at edge 1; done pulses in the cycle after edge 1; busy high for one cycle.
- Not defined: divide by zero runs the full WIDTH iterations.
- HI/LO results are bit-identical with and without the macro; only latency differs. Multiply latency is unaffected in both builds.

Test Plan:
- Reset: reset=1 for 2 cycles with prior hi/lo nonzero -> hi=0, lo=0, busy=0, done=0.
- MULT: rs=0xFFFFFFFE (-2), rt=0x00000003 -> after 34 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for 1 cycle. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV: rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. done after 34 cycles without the macro; after 2 cycles with MULDIV_EARLY_OUT_EN.
- Busy interaction: MULTU 5x7 started; at cycle 10 assert start with new operands and hi_we with wrdata=0xDEAD -> both ignored; final hi=0, lo=35. Then hi_we=1, wrdata=0xDEAD while idle -> hi=0xDEAD next cycle.
- Reset mid-op: DIVU 100/7, reset at cycle 15 -> busy=0, hi=lo=0, no done pulse. New start after reset -> lo=14, hi=2.
